// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter
//
// Lets instruction fetch (IF) and data load (MEM) share one AXI3 read port.
// The two requesters compete for the AR channel. Each issued read is tagged
// with that requester's ARID. Returning R beats are steered by RID into a
// one-entry response buffer per requester. Each requester may have at most one
// read in flight, so the port carries no more than two reads at once.
//
// Ports
//   clk, reset               clock; asynchronous active-low reset
//   if_req_*  / mem_req_*    request handshake (valid/addr in, ready out)
//   if_resp_* / mem_resp_*   response buffer (valid/data out, ready in)
//   arid, araddr, arvalid    AR channel towards the interconnect
//   arready                  AR channel acceptance
//   arlen .. arprot          fixed AR attributes (single 32-bit beat)
//   rid, rdata, rresp, rlast, rvalid, rready   R channel
//   protocol_err             sticky flag for stray or malformed R beats
module axi_read_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [3:0]  IF_ID        = 4'd0,
  parameter logic [3:0]  MEM_ID       = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  input  logic        if_resp_ready,
  input  logic        mem_req_valid,
  input  logic [31:0] mem_req_addr,
  output logic        mem_req_ready,
  output logic        mem_resp_valid,
  output logic [31:0] mem_resp_data,
  input  logic        mem_resp_ready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        protocol_err
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic {AR_IDLE, AR_BUSY} ar_state_t;

  ar_state_t  state;
  logic       ar_is_mem;
  logic       if_out;
  logic       mem_out;
  logic [3:0] starve_cnt;

  logic if_elig;
  logic mem_elig;
  logic force_if;
  logic grant_if;
  logic grant_mem;
  logic ar_done;
  logic hit_if;
  logic hit_mem;
  logic r_fire;
  logic if_hs;
  logic mem_hs;

  // Map the kseg0/kseg1-style windows (0x8000_0000..0xBFFF_FFFF) onto
  // physical address 0. Every other address passes through unchanged.
  function automatic logic [31:0] map_addr(input logic [31:0] a);
    logic [31:0] m;
    m = a;
    if (a[31:29] == 3'b100 || a[31:29] == 3'b101) m = {3'b000, a[28:0]};
    return m;
  endfunction

  assign arlen   = 4'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b00;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b001;

  // MEM normally wins the arbitration. Once MEM has been granted STARVE_LIMIT
  // times while IF was waiting, IF takes the next slot.
  assign if_elig   = if_req_valid & ~if_out;
  assign mem_elig  = mem_req_valid & ~mem_out;
  assign force_if  = if_elig & (starve_cnt == STARVE_MAX);
  assign grant_mem = (state == AR_IDLE) & mem_elig & ~force_if;
  assign grant_if  = (state == AR_IDLE) & if_elig & ~grant_mem;

  assign if_req_ready  = grant_if;
  assign mem_req_ready = grant_mem;

  assign ar_done = (state == AR_BUSY) & arready;

  // Accept a beat when its owner has room for it. Accept and discard a beat
  // whose RID belongs to no read in flight, for example one abandoned by a
  // reset. Hold rready low while reset is asserted.
  assign hit_if  = (rid == IF_ID) & if_out;
  assign hit_mem = (rid == MEM_ID) & mem_out;
  assign rready  = reset & (hit_if  ? ~if_resp_valid :
                            hit_mem ? ~mem_resp_valid : 1'b1);
  assign r_fire  = rvalid & rready;

  assign if_hs  = if_resp_valid & if_resp_ready;
  assign mem_hs = mem_resp_valid & mem_resp_ready;

  // The AR issue FSM, the starvation counter and the in-flight bits.
  // A requester stays marked as in flight from its AR handshake until its
  // buffered response is consumed. This keeps each requester to one read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= AR_IDLE;
      arvalid    <= 1'b0;
      araddr     <= 32'd0;
      arid       <= 4'd0;
      ar_is_mem  <= 1'b0;
      if_out     <= 1'b0;
      mem_out    <= 1'b0;
      starve_cnt <= 4'd0;
    end else begin
      case (state)
        AR_IDLE: begin
          if (grant_if || grant_mem) begin
            araddr    <= map_addr(grant_mem ? mem_req_addr : if_req_addr);
            arid      <= grant_mem ? MEM_ID : IF_ID;
            ar_is_mem <= grant_mem;
            arvalid   <= 1'b1;
            state     <= AR_BUSY;
          end
        end
        AR_BUSY: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= AR_IDLE;
          end
        end
        default: state <= AR_IDLE;
      endcase

      if (grant_if) begin
        starve_cnt <= 4'd0;
      end else if (grant_mem && if_elig && starve_cnt != 4'hF) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      if (ar_done && !ar_is_mem) begin
        if_out <= 1'b1;
      end else if (if_hs) begin
        if_out <= 1'b0;
      end

      if (ar_done && ar_is_mem) begin
        mem_out <= 1'b1;
      end else if (mem_hs) begin
        mem_out <= 1'b0;
      end
    end
  end

  // The one-entry response buffers and the sticky error flag. A beat is still
  // delivered when it carries an error response or lacks rlast; the error is
  // only recorded in protocol_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_resp_valid  <= 1'b0;
      if_resp_data   <= 32'd0;
      mem_resp_valid <= 1'b0;
      mem_resp_data  <= 32'd0;
      protocol_err   <= 1'b0;
    end else begin
      if (r_fire && hit_if) begin
        if_resp_valid <= 1'b1;
        if_resp_data  <= rdata;
      end else if (if_hs) begin
        if_resp_valid <= 1'b0;
      end

      if (r_fire && hit_mem) begin
        mem_resp_valid <= 1'b1;
        mem_resp_data  <= rdata;
      end else if (mem_hs) begin
        mem_resp_valid <= 1'b0;
      end

      if (r_fire && (!(hit_if || hit_mem) || rresp != 2'b00 || !rlast)) begin
        protocol_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter
//
// Bench for axi_read_arbiter. A monitor runs on every falling edge. It keeps
// a transaction-level picture of the arbiter: which requesters are in flight,
// which response buffers are full, how many times IF has been passed over,
// and the sticky error. From that picture it predicts the handshakes at the
// coming edge. Returned data is queued per requester and compared when the
// requester consumes its response. A directed section runs first, followed by
// randomized traffic against an out-of-order AXI slave.
module tb_axi_read_arbiter;

  localparam int         STARVE_LIMIT = 4;
  localparam logic [3:0] IF_ID        = 4'd0;
  localparam logic [3:0] MEM_ID       = 4'd1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready;
  logic [31:0] if_req_addr, if_resp_data;
  logic        mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_req_addr, mem_resp_data;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [3:0]  arlen, arcache;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready, protocol_err;

  always #5 clk = ~clk;

  axi_read_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT), .IF_ID(IF_ID), .MEM_ID(MEM_ID)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data), .if_resp_ready(if_resp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_ready(mem_resp_ready),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .protocol_err(protocol_err)
  );

  int checks = 0;
  int failures = 0;

  // Reference state, described in terms of transactions.
  bit [1:0]    m_out;
  bit [1:0]    m_full;
  bit          m_ar_pend;
  int          m_ar_x;
  logic [31:0] m_ar_addr;
  int          m_starve;
  bit          m_perr;
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_mem_q[$];
  int          pend_q[$];

  // Handshakes the monitor expects at the coming edge, for the drivers.
  bit if_acc, mem_acc, r_fire;

  bit ie, me, gi, gm, hit, if_hs, mem_hs, rf;
  int rx;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_map(input logic [31:0] a);
    logic [2:0] top;
    top = a[31:29];
    if (top == 3'd4 || top == 3'd5) return a - 32'h8000_0000 - ((top == 3'd5) ? 32'h2000_0000 : 32'h0);
    return a;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      check_output("rst_arvalid", arvalid, 0);
      check_output("rst_araddr", araddr, 0);
      check_output("rst_arid", arid, 0);
      check_output("rst_rready", rready, 0);
      check_output("rst_if_resp_valid", if_resp_valid, 0);
      check_output("rst_mem_resp_valid", mem_resp_valid, 0);
      check_output("rst_protocol_err", protocol_err, 0);
      m_out = 0; m_full = 0; m_ar_pend = 0; m_starve = 0; m_perr = 0;
      exp_if_q.delete(); exp_mem_q.delete(); pend_q.delete();
      if_acc = 0; mem_acc = 0; r_fire = 0;
    end else begin
      ie = if_req_valid && !m_out[0];
      me = mem_req_valid && !m_out[1];
      gi = !m_ar_pend && ie && (!me || m_starve == STARVE_LIMIT);
      gm = !m_ar_pend && me && !gi;
      check_output("if_req_ready", if_req_ready, gi);
      check_output("mem_req_ready", mem_req_ready, gm);
      check_output("arvalid", arvalid, m_ar_pend);
      if (m_ar_pend) begin
        check_output("araddr", araddr, m_ar_addr);
        check_output("arid", arid, (m_ar_x == 1) ? MEM_ID : IF_ID);
      end
      hit = 0; rx = 0;
      if (rid == IF_ID) begin rx = 0; hit = m_out[0]; end
      else if (rid == MEM_ID) begin rx = 1; hit = m_out[1]; end
      check_output("rready", rready, hit ? !m_full[rx] : 1'b1);
      rf = rvalid && (hit ? !m_full[rx] : 1'b1);
      check_output("if_resp_valid", if_resp_valid, m_full[0]);
      check_output("mem_resp_valid", mem_resp_valid, m_full[1]);
      check_output("protocol_err", protocol_err, m_perr);

      if_hs  = m_full[0] && if_resp_ready;
      mem_hs = m_full[1] && mem_resp_ready;
      if (if_hs) begin
        if (exp_if_q.size() == 0) check_output("if_resp_unexpected", 1, 0);
        else check_output("if_resp_data", if_resp_data, exp_if_q.pop_front());
        m_full[0] = 0; m_out[0] = 0;
      end
      if (mem_hs) begin
        if (exp_mem_q.size() == 0) check_output("mem_resp_unexpected", 1, 0);
        else check_output("mem_resp_data", mem_resp_data, exp_mem_q.pop_front());
        m_full[1] = 0; m_out[1] = 0;
      end
      if (rf) begin
        if (hit) begin
          m_full[rx] = 1;
          if (rx == 0) exp_if_q.push_back(rdata); else exp_mem_q.push_back(rdata);
          if (rresp != 2'b00 || !rlast) m_perr = 1;
        end else begin
          m_perr = 1;
        end
      end
      if (m_ar_pend && arready) begin
        m_ar_pend = 0;
        m_out[m_ar_x] = 1;
        pend_q.push_back(m_ar_x);
      end else if (gi || gm) begin
        m_ar_pend = 1;
        m_ar_x    = gm ? 1 : 0;
        m_ar_addr = ref_map(gm ? mem_req_addr : if_req_addr);
        if (gi) m_starve = 0;
        else if (ie && m_starve < 15) m_starve++;
      end
      if_acc = gi; mem_acc = gm; r_fire = rf;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of random stimulus: an AXI slave that answers in random order,
  // plus two requesters whose valid, address and response-ready are random.
  task automatic apply_stimulus(input bit allow_new);
    int idx;
    arready = allow_new ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (!rvalid || r_fire) begin
      rvalid = 1'b0;
      rid    = 4'($urandom_range(0, 15));
      if (pend_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        idx = $urandom_range(0, pend_q.size() - 1);
        rid = (pend_q[idx] == 1) ? MEM_ID : IF_ID;
        pend_q.delete(idx);
        rdata  = $urandom;
        rresp  = 2'b00;
        rlast  = 1'b1;
        rvalid = 1'b1;
      end
    end
    if (!allow_new) begin
      if_req_valid = 0; mem_req_valid = 0;
      if_resp_ready = 1; mem_resp_ready = 1;
    end else begin
      if (if_req_valid && (if_acc || $urandom_range(0, 3) == 0)) if_req_valid = 0;
      if (!if_req_valid && $urandom_range(0, 1) == 1) begin
        if_req_valid = 1; if_req_addr = $urandom;
      end
      if (mem_req_valid && (mem_acc || $urandom_range(0, 7) == 0)) mem_req_valid = 0;
      if (!mem_req_valid && $urandom_range(0, 3) != 0) begin
        mem_req_valid = 1; mem_req_addr = $urandom;
      end
      if_resp_ready  = ($urandom_range(0, 2) == 0);
      mem_resp_ready = ($urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    if_req_valid = 0; if_req_addr = 0; if_resp_ready = 0;
    mem_req_valid = 0; mem_req_addr = 0; mem_resp_ready = 0;
    arready = 0; rid = 4'hF; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    check_output("arsize", arsize, 3'b010);
    check_output("arprot", arprot, 3'b001);
    check_output("arlen", arlen, 0);
    check_output("arburst_lock_cache", {arburst, arlock, arcache}, 0);

    // Single IF read through a remapped address, with AR accepted two cycles late.
    step(); if_req_valid = 1; if_req_addr = 32'hBFC0_0000;
    @(negedge clk); check_output("d1_if_req_ready", if_req_ready, 1);
    step(); if_req_valid = 0;
    @(negedge clk);
    check_output("d1_arvalid", arvalid, 1);
    check_output("d1_araddr", araddr, 32'h1FC0_0000);
    check_output("d1_arid", arid, 0);
    step();
    step(); arready = 1;
    step(); arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h3C08_0001;
    @(negedge clk);
    check_output("d1_rready", rready, 1);
    check_output("d1_resp_not_yet", if_resp_valid, 0);
    step(); rvalid = 0; rid = 4'hF;
    @(negedge clk);
    check_output("d1_if_resp_valid", if_resp_valid, 1);
    check_output("d1_if_resp_data", if_resp_data, 32'h3C08_0001);
    step(); if_resp_ready = 1;
    step(); if_resp_ready = 0;
    @(negedge clk); check_output("d1_resp_cleared", if_resp_valid, 0);

    // Both request together: MEM first, then IF; responses return out of order.
    step(); if_req_valid = 1; if_req_addr = 32'h0000_1000;
    mem_req_valid = 1; mem_req_addr = 32'hA000_0040;
    @(negedge clk);
    check_output("d2_mem_first", mem_req_ready, 1);
    check_output("d2_if_waits", if_req_ready, 0);
    step(); mem_req_valid = 0; arready = 1;
    @(negedge clk);
    check_output("d2_mem_arid", arid, 1);
    check_output("d2_mem_araddr", araddr, 32'h0000_0040);
    step(); arready = 0;
    @(negedge clk); check_output("d2_if_next", if_req_ready, 1);
    step(); if_req_valid = 0; arready = 1;
    @(negedge clk);
    check_output("d2_if_arid", arid, 0);
    check_output("d2_if_araddr", araddr, 32'h0000_1000);
    step(); arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'hDEAD_BEEF;
    @(negedge clk); check_output("d2_rready_mem", rready, 1);
    step(); rid = 4'd0; rdata = 32'h1234_5678;
    @(negedge clk);
    check_output("d2_rready_if", rready, 1);
    check_output("d2_mem_resp_valid", mem_resp_valid, 1);
    step(); rvalid = 0; rid = 4'hF;
    @(negedge clk);
    check_output("d2_mem_data", mem_resp_data, 32'hDEAD_BEEF);
    check_output("d2_if_data", if_resp_data, 32'h1234_5678);
    step(); if_resp_ready = 1; mem_resp_ready = 1;
    step(); if_resp_ready = 0; mem_resp_ready = 0;
    @(negedge clk); check_output("d2_both_empty", {if_resp_valid, mem_resp_valid}, 0);

    // Starvation: IF is present only at the arbitration points, so after four MEM wins it is forced.
    for (int k = 0; k < 5; k++) begin
      step(); if_req_valid = 1; if_req_addr = 32'h100 + k; mem_req_valid = 1; mem_req_addr = 32'h200 + k;
      @(negedge clk);
      check_output("d4_if_grant", if_req_ready, (k == 4) ? 1 : 0);
      check_output("d4_mem_grant", mem_req_ready, (k == 4) ? 0 : 1);
      step(); if_req_valid = 0; mem_req_valid = 0; arready = 1;
      step(); arready = 0; rvalid = 1; rid = (k == 4) ? 4'd0 : 4'd1; rdata = 32'hC0DE_0000 + k;
      step(); rvalid = 0; rid = 4'hF; if_resp_ready = 1; mem_resp_ready = 1;
      step(); if_resp_ready = 0; mem_resp_ready = 0;
    end
    step(); if_req_valid = 1; mem_req_valid = 1;
    @(negedge clk); check_output("d4_counter_cleared", mem_req_ready, 1);
    step(); if_req_valid = 0; mem_req_valid = 0;

    // Reset while an AR is pending; the abandoned read's beat is drained.
    #2 reset = 0;
    #1;
    check_output("d3_arvalid", arvalid, 0);
    check_output("d3_araddr", araddr, 0);
    check_output("d3_rready", rready, 0);
    step(); step(); reset = 1;
    step(); if_req_valid = 1; if_req_addr = 32'h8000_0010;
    step(); if_req_valid = 0;
    @(negedge clk); check_output("d3_busy", arvalid, 1);
    #2 reset = 0;
    #1;
    check_output("d3b_arvalid", arvalid, 0);
    check_output("d3b_araddr", araddr, 0);
    check_output("d3b_arid", arid, 0);
    check_output("d3b_rready", rready, 0);
    check_output("d3b_perr", protocol_err, 0);
    step(); step(); reset = 1;
    step(); rvalid = 1; rid = 4'd0; rdata = 32'h0000_55AA;
    @(negedge clk); check_output("d3_drain_rready", rready, 1);
    step(); rvalid = 0; rid = 4'hF;
    @(negedge clk);
    check_output("d3_protocol_err", protocol_err, 1);
    check_output("d3_no_resp", if_resp_valid, 0);

    // Randomized traffic from a clean reset, then a drain.
    step(); reset = 0;
    step(); step(); reset = 1;
    for (int c = 0; c < 3000; c++) begin
      step();
      apply_stimulus(1'b1);
    end
    for (int c = 0; c < 80; c++) begin
      step();
      apply_stimulus(1'b0);
    end
    @(negedge clk);
    check_output("end_if_queue_empty", exp_if_q.size(), 0);
    check_output("end_mem_queue_empty", exp_mem_q.size(), 0);
    check_output("end_nothing_in_flight", {m_ar_pend, m_out}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
